program_sequencer: RTL and testbench
====================================

# program_sequencer

Launch controller for the processor core (`top`). It holds a small table of program entry addresses and runs the selected programs back-to-back. For each program it drives the core's `start`/`start_address`, waits for the core's `done`, and reports the cycle count. It sits between the bench or host and the core, replacing hand-timed start pulses with a deterministic, timeout-guarded handshake.

## Interface
Parameters:
- NUM_PROGS, 4, number of table entries; power of two, ≥2.
- ADDR_W, 7, width of the core's start address.
- START_CYCLES, 1, number of cycles `start` is held high per launch (≥1).
- CYC_W, 16, width of the per-program cycle counter.
- TIMEOUT, 50000, maximum cycles from launch to `done` before aborting (< 2^CYC_W).

Ports (IW = $clog2(NUM_PROGS)):
- clock  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cfg_we  in  1  table write strobe; ignored while `busy`.
- cfg_idx  in  IW  table entry written.
- cfg_addr  in  ADDR_W  entry address written.
- run_count  in  IW+1  number of programs to run, sampled on `go`; values above NUM_PROGS are clamped to NUM_PROGS.
- go  in  1  start-sequence request, one-cycle pulse; ignored while `busy`.
- done  in  1  core completion level.
- start  out  1  core start.
- start_address  out  ADDR_W  core start address.
- busy  out  1  sequence in progress.
- prog_idx  out  IW  index of the current or last program.
- prog_cycles  out  CYC_W  cycles from first `start` cycle to `done` (inclusive), for the last finished program.
- result_valid  out  1  one-cycle pulse when `prog_cycles` updates.
- all_done  out  1  one-cycle pulse at end of sequence (normal or abort).
- timeout  out  1  sticky abort flag; cleared by the next accepted `go` or by reset.

## Operation
- States: IDLE, LAUNCH, ARM, RUN, NEXT.
- IDLE:
  - `go` latches `n` = clamped `run_count` and sets `prog_idx` = 0.
  - If `n` = 0, pulse `all_done` next cycle and stay in IDLE.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - `start` = 1 and `start_address` = table[`prog_idx`] for START_CYCLES cycles, then go to ARM.
  - The cycle counter clears to 1 on the first LAUNCH cycle and increments every cycle after.
- ARM: wait until `done` = 0. This rejects a stale `done` level left by the previous program. Then go to RUN.
- RUN: on `done` = 1:
  - latch `prog_cycles`;
  - pulse `result_valid`;
  - go to NEXT.
- NEXT:
  - If `prog_idx` = `n`−1, pulse `all_done` and go to IDLE.
  - Else increment `prog_idx` and go to LAUNCH.
- Timeout: in LAUNCH, ARM or RUN, when the counter reaches TIMEOUT:
  - set `timeout`, pulse `all_done` and go to IDLE;
  - `result_valid` is not pulsed;
  - `prog_idx` keeps the failing index.
- `start_address` is held at the last launched address outside LAUNCH, and is 0 after reset.
- Table entries reset to 0. Writes land in IDLE only; a write and `go` in the same cycle both take effect, with the write visible to this sequence.
- Cycle counter saturates at 2^CYC_W−1. It cannot reach that value because TIMEOUT is smaller.

## Timing
- Reset values: all outputs 0, state IDLE, table all 0.
- `go` at edge k → `start` = 1 and `busy` = 1 from cycle k+1.
- `busy` is high from LAUNCH entry until the cycle `all_done` pulses, inclusive.
- `done` is a registered input: `done` sampled high at edge m → `result_valid` at m+1 and NEXT at m+1.
- Back-to-back programs: the next LAUNCH begins 2 cycles after `done` is sampled.
- `done` high during LAUNCH is ignored.
- `done` stuck high through ARM leads to timeout.
- `reset_n` low mid-sequence: return to IDLE on that edge, `start` low immediately after, no `all_done` pulse.
- `go` while busy: no effect on state or on `n`.

## Structure
- Package `program_seq_pkg`:
  - state enum `seq_state_t` (IDLE, LAUNCH, ARM, RUN, NEXT);
  - default parameter constants;
  - table entry type `prog_addr_t`.
- One sub-module, `seq_cycle_counter`: clear, enable, saturating, with a terminal-compare output against TIMEOUT.
- Everything else lives in the single FSM module.

## Test plan
- Table {0x00, 0x20, 0x40, 0x7F}, `run_count` = 4, core model asserts `done` 10 cycles after `start` → four launches in index order; each `prog_cycles` = 11; `all_done` pulses once; `timeout` = 0.
- `run_count` = 0 → `all_done` one cycle after `go`; `start` never asserts.
- `done` left high from the previous program and dropped 3 cycles after `start` → no early completion; `prog_cycles` covers the full new run.
- Core never raises `done`, TIMEOUT = 100 → `timeout` = 1 and `all_done` 100 cycles after launch; `prog_idx` holds the failing index; next `go` clears `timeout`.
- `go` and `cfg_we` pulsed while busy → ignored; table contents and current sequence unchanged.
- `reset_n` = 0 during RUN → outputs 0 on the next cycle; a fresh `go` afterward runs cleanly with table entries 0.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared types and default parameters for the program launch sequencer.
package program_seq_pkg;

    localparam int DEF_NUM_PROGS    = 4;
    localparam int DEF_ADDR_W       = 7;
    localparam int DEF_START_CYCLES = 1;
    localparam int DEF_CYC_W        = 16;
    localparam int DEF_TIMEOUT      = 50000;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARM,
        RUN,
        NEXT
    } seq_state_t;

    typedef logic [DEF_ADDR_W-1:0] prog_addr_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Start/done handshake between the sequencer (master) and the processor core (slave).
interface program_sequencer_if #(
    parameter int ADDR_W = 7
);
    logic              start;
    logic [ADDR_W-1:0] start_address;
    logic              done;

    modport master (output start, output start_address, input done);
    modport slave  (input start, input start_address, output done);
endinterface

// File: rtl/program_sequencer_cycle_counter.sv
// Per-program cycle counter: clear, enable, saturate at all-ones, flag the abort limit.
module seq_cycle_counter #(
    parameter int CYC_W   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [CYC_W-1:0] count,
    output logic             terminal
);

    logic [CYC_W-1:0] count_q;
    logic [CYC_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == CYC_W'(TIMEOUT));

endmodule

// File: rtl/program_sequencer.sv
// Runs a table of core entry addresses back-to-back, timing each program and
// aborting any program whose done does not arrive within TIMEOUT cycles.
module program_sequencer
    import program_seq_pkg::*;
#(
    parameter int NUM_PROGS    = DEF_NUM_PROGS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int START_CYCLES = DEF_START_CYCLES,
    parameter int CYC_W        = DEF_CYC_W,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    localparam int IW          = $clog2(NUM_PROGS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cfg_we,
    input  logic [IW-1:0]       cfg_idx,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [IW:0]         run_count,
    input  logic                go,
    program_sequencer_if.master core,
    output logic                busy,
    output logic [IW-1:0]       prog_idx,
    output logic [CYC_W-1:0]    prog_cycles,
    output logic                result_valid,
    output logic                all_done,
    output logic                timeout
);

    seq_state_t        state_q, state_d;
    logic [IW:0]       n_q, n_d;
    logic [IW-1:0]     prog_idx_q, prog_idx_d;
    logic [CYC_W-1:0]  prog_cycles_q, prog_cycles_d;
    logic              result_valid_q, result_valid_d;
    logic              zero_done_q, zero_done_d;
    logic              timeout_q, timeout_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q;
    logic [ADDR_W-1:0] table_q [NUM_PROGS];
    logic [ADDR_W-1:0] table_d [NUM_PROGS];

    logic              cfg_write;
    logic [NUM_PROGS-1:0] wr_hit;
    logic [IW:0]       n_req;
    logic [ADDR_W-1:0] launch_addr;
    logic              start_c;
    logic              all_done_c;
    logic              cnt_clr;
    logic              cnt_en;
    logic [CYC_W-1:0]  cnt;
    logic              cnt_term;

    assign cfg_write   = cfg_we && (state_q == IDLE);
    assign n_req       = (run_count > (IW+1)'(NUM_PROGS)) ? (IW+1)'(NUM_PROGS) : run_count;
    assign launch_addr = table_q[prog_idx_q];

    for (genvar gi = 0; gi < NUM_PROGS; gi++) begin : g_wr_hit
        assign wr_hit[gi] = cfg_write && (cfg_idx == IW'(gi));
    end

    always_comb begin
        for (int i = 0; i < NUM_PROGS; i++) begin
            table_d[i] = wr_hit[i] ? cfg_addr : table_q[i];
        end
    end

    // Counter is held at 0 outside the active states, so it reads j in the
    // j-th cycle after launch and prog_cycles counts start..done inclusive.
    seq_cycle_counter #(
        .CYC_W   (CYC_W),
        .TIMEOUT (TIMEOUT)
    ) u_cycle_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .count    (cnt),
        .terminal (cnt_term)
    );

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        prog_idx_d     = prog_idx_q;
        prog_cycles_d  = prog_cycles_q;
        result_valid_d = 1'b0;
        zero_done_d    = 1'b0;
        timeout_d      = timeout_q;
        addr_d         = addr_q;
        start_c        = 1'b0;
        all_done_c     = 1'b0;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (go) begin
                    n_d        = n_req;
                    prog_idx_d = '0;
                    timeout_d  = 1'b0;
                    if (n_req == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                cnt_en  = 1'b1;
                start_c = 1'b1;
                addr_d  = launch_addr;
                if (cnt_term) begin
                    timeout_d  = 1'b1;
                    all_done_c = 1'b1;
                    state_d    = IDLE;
                end else if (cnt == CYC_W'(START_CYCLES - 1)) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                cnt_en = 1'b1;
                if (cnt_term) begin
                    timeout_d  = 1'b1;
                    all_done_c = 1'b1;
                    state_d    = IDLE;
                end else if (!done_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                if (cnt_term) begin
                    timeout_d  = 1'b1;
                    all_done_c = 1'b1;
                    state_d    = IDLE;
                end else if (done_q) begin
                    prog_cycles_d  = cnt;
                    result_valid_d = 1'b1;
                    state_d        = NEXT;
                end
            end
            NEXT: begin
                cnt_clr = 1'b1;
                if (({1'b0, prog_idx_q} + (IW+1)'(1)) == n_q) begin
                    all_done_c = 1'b1;
                    state_d    = IDLE;
                end else begin
                    prog_idx_d = prog_idx_q + 1'b1;
                    state_d    = LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            n_q            <= '0;
            prog_idx_q     <= '0;
            prog_cycles_q  <= '0;
            result_valid_q <= 1'b0;
            zero_done_q    <= 1'b0;
            timeout_q      <= 1'b0;
            addr_q         <= '0;
            done_q         <= 1'b0;
            for (int i = 0; i < NUM_PROGS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            prog_idx_q     <= prog_idx_d;
            prog_cycles_q  <= prog_cycles_d;
            result_valid_q <= result_valid_d;
            zero_done_q    <= zero_done_d;
            timeout_q      <= timeout_d;
            addr_q         <= addr_d;
            done_q         <= core.done;
            table_q        <= table_d;
        end
    end

    assign core.start         = start_c;
    assign core.start_address = (state_q == LAUNCH) ? launch_addr : addr_q;
    assign busy               = (state_q != IDLE);
    assign prog_idx           = prog_idx_q;
    assign prog_cycles        = prog_cycles_q;
    assign result_valid       = result_valid_q;
    assign all_done           = all_done_c | zero_done_q;
    assign timeout            = timeout_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a behavioural core driving done.
module tb_program_sequencer;
    import program_seq_pkg::*;

    localparam int NP = 4;
    localparam int AW = 7;
    localparam int SC = 1;
    localparam int CW = 16;
    localparam int TO = 100;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_addr;
    logic [IW:0]   run_count;
    logic          go;
    logic          busy;
    logic [IW-1:0] prog_idx;
    logic [CW-1:0] prog_cycles;
    logic          result_valid;
    logic          all_done;
    logic          timeout;

    program_sequencer_if #(.ADDR_W(AW)) core_if ();

    program_sequencer #(
        .NUM_PROGS    (NP),
        .ADDR_W       (AW),
        .START_CYCLES (SC),
        .CYC_W        (CW),
        .TIMEOUT      (TO)
    ) dut (
        .clock        (clk),
        .reset_n      (reset_n),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_addr     (cfg_addr),
        .run_count    (run_count),
        .go           (go),
        .core         (core_if),
        .busy         (busy),
        .prog_idx     (prog_idx),
        .prog_cycles  (prog_cycles),
        .result_valid (result_valid),
        .all_done     (all_done),
        .timeout      (timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Core model: done drops drop_at cycles after start, rises done_at cycles after start.
    int   drop_at = 1;
    int   done_at = 10;
    int   hang_at = -1;
    int   core_cnt = 0;
    int   core_t = 0;
    bit   core_active = 1'b0;
    logic core_done = 1'b0;
    assign core_if.done = core_done;

    always @(negedge clk) begin
        if (!reset_n) begin
            core_active = 1'b0;
            core_done   = 1'b0;
        end else begin
            if (core_if.start && !core_active) begin
                core_active = 1'b1;
                core_t      = 0;
                core_cnt++;
            end else if (core_active) begin
                core_t++;
            end
            if (core_active) begin
                if (core_t == drop_at) core_done = 1'b0;
                if (core_t == done_at) begin
                    if (core_cnt != hang_at) core_done = 1'b1;
                    core_active = 1'b0;
                end
            end
        end
    end

    // Monitor: samples the cycle just ending at each rising edge.
    prog_addr_t l_addr[$];
    int         l_idx[$];
    int         l_cyc[$];
    int         rv_vals[$];
    int         ad_cnt = 0;
    int         ad_cyc = 0;
    int         cyc = 0;
    bit         prev_start = 1'b0;

    always @(posedge clk) begin
        if (core_if.start && !prev_start) begin
            l_addr.push_back(core_if.start_address);
            l_idx.push_back(int'(prog_idx));
            l_cyc.push_back(cyc);
            $display("launch idx=%0d addr=0x%0h cycle=%0d", prog_idx, core_if.start_address, cyc);
        end
        prev_start = core_if.start;
        if (result_valid) begin
            rv_vals.push_back(int'(prog_cycles));
            $display("result idx=%0d cycles=%0d", prog_idx, prog_cycles);
        end
        if (all_done) begin
            ad_cnt++;
            ad_cyc = cyc;
            $display("all_done idx=%0d cycle=%0d", prog_idx, cyc);
        end
        cyc++;
    end

    task automatic write_tbl(input int idx, input int addr);
        cfg_we   = 1'b1;
        cfg_idx  = IW'(idx);
        cfg_addr = AW'(addr);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_go(input int rc);
        run_count = (IW+1)'(rc);
        go        = 1'b1;
        @(negedge clk);
        go        = 1'b0;
    endtask

    task automatic wait_all_done(input int budget);
        int a0 = ad_cnt;
        int n  = 0;
        while (ad_cnt == a0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("all_done_once", ad_cnt - a0, 1);
    endtask

    task automatic check_launches(input string tag, input int base, input int cnt,
                                  input int a0, input int a1, input int a2, input int a3);
        int exp_a[4];
        exp_a = '{a0, a1, a2, a3};
        check_eq({tag, "_launch_count"}, l_addr.size() - base, cnt);
        for (int i = 0; i < cnt; i++) begin
            if (l_addr.size() > base + i) begin
                check_eq({tag, "_addr"}, 32'(l_addr[base + i]), exp_a[i]);
                check_eq({tag, "_idx"}, l_idx[base + i], i);
            end
        end
    endtask

    task automatic check_results(input string tag, input int base, input int cnt);
        check_eq({tag, "_result_count"}, rv_vals.size() - base, cnt);
        for (int i = 0; i < cnt; i++) begin
            if (rv_vals.size() > base + i) check_eq({tag, "_cycles"}, rv_vals[base + i], 11);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_start"}, core_if.start, 0);
        check_eq({tag, "_start_address"}, core_if.start_address, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_prog_idx"}, prog_idx, 0);
        check_eq({tag, "_prog_cycles"}, prog_cycles, 0);
        check_eq({tag, "_result_valid"}, result_valid, 0);
        check_eq({tag, "_all_done"}, all_done, 0);
        check_eq({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lb, rb, ab;
        reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0;
        run_count = '0; go = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Four programs, table {00,20,40,7F}
        write_tbl(0, 'h00); write_tbl(1, 'h20); write_tbl(2, 'h40); write_tbl(3, 'h7F);
        lb = l_addr.size(); rb = rv_vals.size();
        pulse_go(4);
        check_eq("t1_start_after_go", core_if.start, 1);
        check_eq("t1_busy_after_go", busy, 1);
        check_eq("t1_first_address", core_if.start_address, 'h00);
        wait_all_done(300);
        check_launches("t1", lb, 4, 'h00, 'h20, 'h40, 'h7F);
        check_results("t1", rb, 4);
        if (l_cyc.size() > lb + 1) check_eq("t1_launch_spacing", l_cyc[lb + 1] - l_cyc[lb], 13);
        check_eq("t1_busy_end", busy, 0);
        check_eq("t1_prog_idx_end", prog_idx, 3);
        check_eq("t1_timeout", timeout, 0);
        check_eq("t1_addr_held", core_if.start_address, 'h7F);

        // run_count = 0
        lb = l_addr.size(); ab = ad_cnt;
        pulse_go(0);
        check_eq("t2_all_done_next", all_done, 1);
        check_eq("t2_busy", busy, 0);
        repeat (5) @(negedge clk);
        check_eq("t2_all_done_count", ad_cnt - ab, 1);
        check_eq("t2_no_launch", l_addr.size() - lb, 0);

        // Stale done from previous program, dropped 3 cycles after start
        drop_at = 3;
        lb = l_addr.size(); rb = rv_vals.size();
        pulse_go(1);
        wait_all_done(100);
        check_launches("t3", lb, 1, 'h00, 0, 0, 0);
        check_results("t3", rb, 1);

        // go and cfg_we while busy are ignored
        lb = l_addr.size(); rb = rv_vals.size(); ab = ad_cnt;
        pulse_go(2);
        repeat (3) @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_addr = 7'h55; run_count = 3'd4; go = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; go = 1'b0;
        wait_all_done(200);
        check_launches("t5", lb, 2, 'h00, 'h20, 0, 0);
        check_results("t5", rb, 2);

        // Write together with go is visible; run_count 7 clamps to 4
        lb = l_addr.size(); rb = rv_vals.size();
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 7'h11; run_count = 3'd7; go = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; go = 1'b0;
        wait_all_done(300);
        check_launches("t7", lb, 4, 'h11, 'h20, 'h40, 'h7F);
        check_results("t7", rb, 4);

        // Second program hangs -> timeout after TIMEOUT cycles
        lb = l_addr.size(); rb = rv_vals.size();
        hang_at = core_cnt + 2;
        pulse_go(3);
        wait_all_done(400);
        check_launches("t4", lb, 2, 'h11, 'h20, 0, 0);
        check_results("t4", rb, 1);
        if (l_cyc.size() > lb + 1) check_eq("t4_abort_latency", ad_cyc - l_cyc[lb + 1], TO);
        check_eq("t4_timeout_set", timeout, 1);
        check_eq("t4_failing_idx", prog_idx, 1);
        check_eq("t4_busy", busy, 0);
        pulse_go(0);
        check_eq("t4_timeout_cleared", timeout, 0);
        repeat (2) @(negedge clk);

        // Reset in the middle of RUN
        pulse_go(2);
        repeat (6) @(negedge clk);
        check_eq("t6_busy_before_reset", busy, 1);
        ab = ad_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6_no_all_done", ad_cnt - ab, 0);
        lb = l_addr.size(); rb = rv_vals.size();
        pulse_go(4);
        wait_all_done(300);
        check_launches("t6", lb, 4, 0, 0, 0, 0);
        check_results("t6", rb, 4);
        check_eq("t6_timeout", timeout, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
